mac_rx_frame_buffer: RTL and testbench
======================================

Name: mac_rx_frame_buffer

Overview:
- Parametrised GMII receive front end for the Ethernet RX path.
- Strips the preamble and SFD, and filters on destination MAC.
- Classifies frames by EtherType into NUM_CH channels and checks FCS (CRC-32) internally.
- Buffers whole frames with commit/rollback, so only good frames reach the downstream ARP/IP/UDP parsers. Those frames are presented as a valid/ready byte stream with a per-frame descriptor.

Parameters:
- DATA_DEPTH, 4096: frame byte RAM depth, power of two.
- DESC_DEPTH, 16: descriptor FIFO depth, power of two.
- NUM_CH, 4: number of EtherType match entries.
- MIN_LEN, 64: minimum frame length including FCS.
- MAX_LEN, 1518: maximum frame length including FCS.

Ports:
- clk  in  1  receive clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_dv  in  1  GMII data valid.
- mac_rx_datain  in  8  GMII data.
- local_mac_addr  in  48  station MAC; byte 0 = bits [47:40].
- promisc  in  1  1 = accept any destination MAC.
- drop_unknown  in  1  1 = drop frames with no EtherType match.
- ethertype_tbl  in  16*NUM_CH  entry i at bits [16i+15:16i].
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  frame byte; starts at destination MAC, FCS excluded.
- out_sop  out  1  first byte of frame.
- out_eop  out  1  last byte of frame.
- out_len  out  11  frame length excluding FCS; valid from out_sop until out_eop accepted.
- out_ch  out  clog2(NUM_CH+1)  matched entry index; NUM_CH = unknown.
- cnt_good, cnt_crc_err, cnt_filt_drop, cnt_ovf  out  16 each  saturating event counters.

Behaviour:
- Reset: all outputs 0, pointers 0, both FIFOs empty, write FSM in IDLE, read FSM idle.
- Write FSM, state IDLE:
  - rx_dv=1 with byte 0x55 -> PRE.
  - rx_dv=1 with byte 0xD5 -> FRAME, zero preamble bytes allowed.
  - rx_dv=1 with any other byte -> DROP.
- Write FSM, state PRE:
  - 0x55 -> stay.
  - 0xD5 -> FRAME.
  - any other byte -> DROP.
  - rx_dv=0 -> IDLE, no counter change.
- Write FSM, state FRAME: each rx_dv=1 byte is written at wr_tmp, then wr_tmp++ modulo DATA_DEPTH and byte count cnt++. In the same pass:
  - CRC-32 is updated: reflected polynomial 0xEDB88320, LSB first, init 0xFFFFFFFF.
  - Bytes 0-5 are compared with local_mac_addr or FF:FF:FF:FF:FF:FF.
  - Bytes 12-13 (big-endian) are matched against the table; the lowest matching index wins.
- Write FSM, state DROP: wait for rx_dv=0, roll back wr_tmp to wr_ptr, then -> IDLE.
- Overflow in FRAME: if (wr_tmp - rd_ptr) == DATA_DEPTH, or cnt would exceed MAX_LEN:
  - the byte is not written;
  - cnt_ovf increments;
  - the FSM goes to DROP.
- End of frame (rx_dv falls in FRAME): the frame is judged in the following cycle.
  - Commit requires all of: CRC register == 0xDEBB20E3, cnt >= MIN_LEN, destination match or promisc, (channel != NUM_CH) or !drop_unknown, and descriptor FIFO not full.
  - Commit: wr_ptr <= wr_tmp; push {cnt-4, ch}; cnt_good++.
  - Otherwise roll back wr_tmp <= wr_ptr.
  - Rejection counting: CRC or length failure -> cnt_crc_err++. Filter or unknown-type reject -> cnt_filt_drop++. Descriptor FIFO full -> cnt_ovf++.
  - Exactly one counter changes per judged frame, in priority ovf > crc > filt.
- Back-to-back frames: a new preamble is accepted in the cycle after the judge cycle. Any rx_dv=1 during the judge cycle is ignored until rx_dv next returns low.
- Read side:
  - When the descriptor FIFO is non-empty and the reader is idle, pop the descriptor, latch out_len/out_ch, and read RAM (1-cycle synchronous read) from rd_ptr.
  - Present out_len bytes: out_sop on the first, out_eop on the last.
  - A byte advances only on out_valid & out_ready.
  - out_valid, out_data, out_sop and out_eop hold while out_ready=0.
  - With out_ready held high: one byte per cycle within a frame, at most 2 idle cycles between frames.
  - After out_eop is accepted, rd_ptr advances an extra 4 (skipping FCS) modulo DATA_DEPTH, which frees space.
- Counters: saturate at 0xFFFF, no wrap.
- Reset mid-frame: the partial frame is discarded and the downstream stream ends immediately (out_valid=0). No pending eop is owed.
- Pointer arithmetic: pointers are clog2(DATA_DEPTH)+1 bits wide, so "full" is distinguishable from "empty".

Test Plan:
- 7x0x55, 0xD5, then a 64-byte broadcast ARP frame (EtherType 0x0806 in entry 1) with valid FCS -> out_len=60, out_ch=1, 60 bytes with sop/eop, cnt_good=1.
- Same frame with one payload bit flipped -> no output, cnt_crc_err=1, wr_ptr unchanged.
- Unicast to a foreign MAC with promisc=0 -> cnt_filt_drop=1. Repeat with promisc=1 -> delivered.
- 1519-byte frame -> cnt_ovf=1, dropped. Next 1518-byte good frame delivered with out_len=1514.
- out_ready=0 while 5 good 64-byte frames arrive, then out_ready=1 -> all 5 frames delivered in order, byte-exact. Also fill until DATA_DEPTH overflow -> the overflowing frame is counted in cnt_ovf, earlier frames intact.
- rst asserted mid-frame and mid-read -> all outputs 0, next good frame delivered correctly.

Source files
------------

// File: rtl/mac_rx_frame_buffer.sv
// Purpose: GMII receive front end. Strips preamble/SFD, filters on destination MAC,
// classifies by EtherType, checks FCS, and stores whole frames with commit/rollback.
// Latency: first out byte about 3 cycles after rx_dv falls (judge, descriptor pop,
// RAM read). Backpressure: out_ready=0 holds the output byte. The RX side never
// stalls; a frame that does not fit is dropped and counted in cnt_ovf.
//
// Ports:
//   clk, rst            - receive clock, synchronous active-high reset
//   rx_dv, mac_rx_datain - GMII receive data valid / byte
//   local_mac_addr      - station MAC, byte 0 in [47:40]
//   promisc             - accept any destination MAC
//   drop_unknown        - drop frames whose EtherType matches no table entry
//   ethertype_tbl       - NUM_CH 16-bit entries, entry i at [16i+15:16i]
//   out_valid/out_ready/out_data/out_sop/out_eop - byte stream, FCS removed
//   out_len, out_ch     - per-frame descriptor (length without FCS, channel)
//   cnt_*               - saturating event counters

// Small synchronous FIFO with first-word-fall-through read data.
// Latency: a push is visible on pop_dat one cycle later.
// Backpressure: push is ignored when full, pop is ignored when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign full    = (wp - rp) == (AW+1)'(DEPTH);
  assign empty   = (wp == rp);
  assign pop_dat = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

module mac_rx_frame_buffer #(
  parameter int DATA_DEPTH = 4096,
  parameter int DESC_DEPTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  localparam int CH_W      = $clog2(NUM_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_dv,
  input  logic [7:0]           mac_rx_datain,
  input  logic [47:0]          local_mac_addr,
  input  logic                 promisc,
  input  logic                 drop_unknown,
  input  logic [16*NUM_CH-1:0] ethertype_tbl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [10:0]          out_len,
  output logic [CH_W-1:0]      out_ch,
  output logic [15:0]          cnt_good,
  output logic [15:0]          cnt_crc_err,
  output logic [15:0]          cnt_filt_drop,
  output logic [15:0]          cnt_ovf
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {W_IDLE, W_PRE, W_FRAME, W_JUDGE, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  typedef struct packed {
    logic [10:0]     len;
    logic [CH_W-1:0] ch;
  } desc_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- write side ----------------
  wstate_t         wstate, w_next;
  logic [PW-1:0]   wr_ptr, wr_tmp;
  logic [10:0]     cnt;
  logic [31:0]     crc, crc_next;
  logic            da_uni, da_bc;
  logic [7:0]      et_hi, mac_byte;
  logic [CH_W-1:0] ch, et_ch;
  logic            ram_we, frame_start, ovf_ev, judge, commit, space_full;
  logic            crc_ok, len_ok, da_ok, type_ok;
  logic [7:0]      frame_ram [DATA_DEPTH];

  // read-side signals used by the write side
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic            desc_full, desc_empty, desc_pop;
  desc_t           desc_in, desc_out;

  assign crc_next   = crc32_byte(crc, mac_rx_datain);
  // Pointers carry one extra bit so a completely full RAM differs from empty.
  assign space_full = (wr_tmp - rd_ptr) == PW'(DATA_DEPTH);

  assign crc_ok  = (crc == 32'hDEBB20E3);  // CRC-32 residue after data + FCS
  assign len_ok  = (cnt >= 11'(MIN_LEN));
  assign da_ok   = da_uni | da_bc | promisc;
  assign type_ok = (ch != CH_W'(NUM_CH)) | !drop_unknown;
  assign commit  = judge & !desc_full & crc_ok & len_ok & da_ok & type_ok;

  // Station MAC byte to compare against frame byte cnt (0..5).
  always_comb begin
    mac_byte = local_mac_addr[47:40];
    case (cnt[2:0])
      3'd1:    mac_byte = local_mac_addr[39:32];
      3'd2:    mac_byte = local_mac_addr[31:24];
      3'd3:    mac_byte = local_mac_addr[23:16];
      3'd4:    mac_byte = local_mac_addr[15:8];
      3'd5:    mac_byte = local_mac_addr[7:0];
      default: mac_byte = local_mac_addr[47:40];
    endcase
  end

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    et_ch = CH_W'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (ethertype_tbl[16*i +: 16] == {et_hi, mac_rx_datain}) et_ch = CH_W'(i);
  end

  always_comb begin
    w_next      = wstate;
    ram_we      = 1'b0;
    frame_start = 1'b0;
    ovf_ev      = 1'b0;
    judge       = 1'b0;
    case (wstate)
      W_IDLE, W_PRE: begin
        if (!rx_dv) begin
          w_next = W_IDLE;
        end else if (mac_rx_datain == 8'h55) begin
          w_next = W_PRE;
        end else if (mac_rx_datain == 8'hD5) begin
          w_next      = W_FRAME;
          frame_start = 1'b1;
        end else begin
          w_next = W_DROP;
        end
      end
      W_FRAME: begin
        if (!rx_dv) begin
          w_next = W_JUDGE;
        end else if (space_full || cnt >= 11'(MAX_LEN)) begin
          ovf_ev = 1'b1;
          w_next = W_DROP;
        end else begin
          ram_we = 1'b1;
        end
      end
      // Activity during the judge cycle is not a valid frame start; discard it.
      W_JUDGE: begin
        judge  = 1'b1;
        w_next = rx_dv ? W_DROP : W_IDLE;
      end
      W_DROP:  if (!rx_dv) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) frame_ram[wr_tmp[AW-1:0]] <= mac_rx_datain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      wr_tmp        <= '0;
      cnt           <= '0;
      crc           <= 32'hFFFFFFFF;
      da_uni        <= 1'b0;
      da_bc         <= 1'b0;
      et_hi         <= '0;
      ch            <= CH_W'(NUM_CH);
      cnt_good      <= '0;
      cnt_crc_err   <= '0;
      cnt_filt_drop <= '0;
      cnt_ovf       <= '0;
    end else begin
      if (frame_start) begin
        cnt    <= '0;
        crc    <= 32'hFFFFFFFF;
        da_uni <= 1'b1;
        da_bc  <= 1'b1;
        ch     <= CH_W'(NUM_CH);
      end
      if (ram_we) begin
        wr_tmp <= wr_tmp + 1'b1;
        cnt    <= cnt + 1'b1;
        crc    <= crc_next;
        if (cnt < 11'd6) begin
          da_uni <= da_uni & (mac_rx_datain == mac_byte);
          da_bc  <= da_bc & (mac_rx_datain == 8'hFF);
        end
        if (cnt == 11'd12) et_hi <= mac_rx_datain;
        if (cnt == 11'd13) ch <= et_ch;
      end
      if (commit) wr_ptr <= wr_tmp;
      else if (judge || wstate == W_DROP) wr_tmp <= wr_ptr;

      // One counter per judged frame: overflow beats CRC/length beats filter.
      if (ovf_ev || (judge && desc_full))     cnt_ovf       <= sat_inc(cnt_ovf);
      else if (judge && !(crc_ok && len_ok))  cnt_crc_err   <= sat_inc(cnt_crc_err);
      else if (judge && !(da_ok && type_ok))  cnt_filt_drop <= sat_inc(cnt_filt_drop);
      if (commit) cnt_good <= sat_inc(cnt_good);
    end
  end

  assign desc_in.len = cnt - 11'd4;
  assign desc_in.ch  = ch;

  sync_fifo #(.W($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit),
    .push_dat (desc_in),
    .pop      (desc_pop),
    .pop_dat  (desc_out),
    .full     (desc_full),
    .empty    (desc_empty)
  );

  // ---------------- read side ----------------
  rstate_t     rstate, r_next;
  logic [10:0] rem;
  logic [7:0]  mem_q;
  logic        accept;

  assign accept   = out_valid & out_ready;
  assign out_data = out_valid ? mem_q : 8'h00;

  always_comb begin
    r_next     = rstate;
    desc_pop   = 1'b0;
    rd_ptr_nxt = rd_ptr;
    case (rstate)
      R_IDLE: begin
        if (!desc_empty) begin
          desc_pop = 1'b1;
          r_next   = R_DATA;
        end
      end
      R_DATA: begin
        if (accept) begin
          // After the last byte, also skip the 4 stored FCS bytes.
          rd_ptr_nxt = out_eop ? rd_ptr + PW'(5) : rd_ptr + 1'b1;
          if (out_eop) r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // The RAM is re-read every cycle at the next address; while stalled the
  // address does not move, so the presented byte holds.
  always_ff @(posedge clk) begin
    mem_q <= frame_ram[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= w_next;
      rstate <= r_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_len   <= '0;
      out_ch    <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (desc_pop) begin
        out_len   <= desc_out.len;
        out_ch    <= desc_out.ch;
        rem       <= desc_out.len;
        out_valid <= 1'b1;
        out_sop   <= 1'b1;
        out_eop   <= (desc_out.len == 11'd1);
      end else if (accept) begin
        out_sop <= 1'b0;
        if (out_eop) begin
          out_valid <= 1'b0;
          out_eop   <= 1'b0;
        end else begin
          rem     <= rem - 1'b1;
          out_eop <= (rem == 11'd2);
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_rx_frame_buffer.sv
// Scoreboard bench for mac_rx_frame_buffer: directed frames, expected bytes queued
// by the driver, compared by an independent monitor on the falling edge.
module tb_mac_rx_frame_buffer;
  localparam logic [47:0] MY_MAC  = 48'h02_00_5E_10_20_30;
  localparam logic [47:0] FOREIGN = 48'h02_00_5E_10_20_31;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  mac_rx_datain;
  logic [47:0] local_mac_addr;
  logic        promisc;
  logic        drop_unknown;
  logic [63:0] ethertype_tbl;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [10:0] out_len;
  logic [2:0]  out_ch;
  logic [15:0] cnt_good, cnt_crc_err, cnt_filt_drop, cnt_ovf;

  always #5 clk = ~clk;

  mac_rx_frame_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .rx_dv          (rx_dv),
    .mac_rx_datain  (mac_rx_datain),
    .local_mac_addr (local_mac_addr),
    .promisc        (promisc),
    .drop_unknown   (drop_unknown),
    .ethertype_tbl  (ethertype_tbl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_len        (out_len),
    .out_ch         (out_ch),
    .cnt_good       (cnt_good),
    .cnt_crc_err    (cnt_crc_err),
    .cnt_filt_drop  (cnt_filt_drop),
    .cnt_ovf        (cnt_ovf)
  );

  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic [10:0] len;
    logic [2:0]  ch;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_ctr(input int g, input int c, input int f, input int o);
    check("cnt_good", 32'(cnt_good), g);
    check("cnt_crc_err", 32'(cnt_crc_err), c);
    check("cnt_filt_drop", 32'(cnt_filt_drop), f);
    check("cnt_ovf", 32'(cnt_ovf), o);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Builds a frame of 'total' bytes including a correct FCS (sent LSB byte first).
  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int total, input int seed);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(16 + i));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 14; i < total - 4; i++) frm.push_back(8'(i * 7 + seed));
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic [2:0] ch);
    exp_t e;
    int   n;
    n = frm.size() - 4;
    for (int i = 0; i < n; i++) begin
      e.d   = frm[i];
      e.sop = (i == 0);
      e.eop = (i == n - 1);
      e.len = 11'(n);
      e.ch  = ch;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv         = 1'b1;
    mac_rx_datain = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_dv         = 1'b0;
      mac_rx_datain = 8'h00;
    end
  endtask

  task automatic send(input int npre);
    for (int i = 0; i < npre; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < frm.size(); i++) drive(frm[i]);
    idle(12);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks that a
  // stalled byte holds until it is taken.
  initial begin : monitor
    logic       stall;
    logic [9:0] held;
    exp_t       e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("hold", 32'({out_valid, out_data, out_sop, out_eop}), 32'({1'b1, held}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected byte: got data 0x%0h sop %0b eop %0b, required no output",
                     out_data, out_sop, out_eop);
          end else begin
            e = exp_q.pop_front();
            check("stream", 32'({out_data, out_sop, out_eop, out_len, out_ch}),
                  32'({e.d, e.sop, e.eop, e.len, e.ch}));
          end
        end
        stall = out_valid && !out_ready;
        held  = {out_data, out_sop, out_eop};
      end
    end
  end

  initial begin : main
    logic [15:0] et;
    rst            = 1'b1;
    rx_dv          = 1'b0;
    mac_rx_datain  = 8'h00;
    local_mac_addr = MY_MAC;
    promisc        = 1'b0;
    drop_unknown   = 1'b1;
    // entry3=0x0806 duplicates entry1 so lowest-index priority is exercised
    ethertype_tbl  = {16'h0806, 16'h86DD, 16'h0806, 16'h0800};
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    check("rst_len_ch", 32'({out_len, out_ch}), 0);
    chk_ctr(0, 0, 0, 0);

    // Broadcast ARP, 64 bytes -> 60 delivered on channel 1
    build(BCAST, 16'h0806, 64, 1);
    expect_frame(3'd1);
    send(7);
    drain(500);
    chk_ctr(1, 0, 0, 0);

    // Same frame with a payload bit flipped -> CRC error, nothing delivered
    build(BCAST, 16'h0806, 64, 2);
    frm[20] = frm[20] ^ 8'h08;
    send(7);
    chk_ctr(1, 1, 0, 0);

    // Foreign unicast: filtered, then accepted in promiscuous mode
    build(FOREIGN, 16'h0800, 64, 3);
    send(7);
    chk_ctr(1, 1, 1, 0);
    promisc = 1'b1;
    expect_frame(3'd0);
    send(7);
    drain(500);
    promisc = 1'b0;
    chk_ctr(2, 1, 1, 0);

    // Unknown EtherType to our MAC: dropped, then delivered on channel NUM_CH
    build(MY_MAC, 16'h1234, 64, 4);
    send(7);
    chk_ctr(2, 1, 2, 0);
    drop_unknown = 1'b0;
    expect_frame(3'd4);
    send(3);
    drain(500);
    drop_unknown = 1'b1;
    chk_ctr(3, 1, 2, 0);

    // Oversize frame, then a maximum-size frame (out_len 1514)
    build(BCAST, 16'h0800, 1519, 5);
    send(7);
    chk_ctr(3, 1, 2, 1);
    build(BCAST, 16'h0800, 1518, 6);
    expect_frame(3'd0);
    send(7);
    drain(3000);
    chk_ctr(4, 1, 2, 1);

    // 63-byte frame with valid FCS -> length error
    build(BCAST, 16'h0806, 63, 7);
    send(7);
    chk_ctr(4, 2, 2, 1);

    // Unicast to our MAC with no preamble, SFD only
    build(MY_MAC, 16'h0806, 64, 8);
    expect_frame(3'd1);
    send(0);
    drain(500);
    chk_ctr(5, 2, 2, 1);

    // Five frames arrive while downstream is stalled, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      et = (k % 3 == 0) ? 16'h0800 : (k % 3 == 1) ? 16'h0806 : 16'h86DD;
      build((k % 2 == 0) ? BCAST : MY_MAC, et, 64, 20 + k);
      expect_frame(3'(k % 3));
      send(7);
    end
    drain(1000);
    chk_ctr(10, 2, 2, 1);

    // Data RAM overflow: two max frames fit, the third does not
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      build(BCAST, 16'h0800, 1518, 30 + k);
      if (k < 2) expect_frame(3'd0);
      send(7);
    end
    chk_ctr(12, 2, 2, 2);
    drain(4000);

    // Descriptor FIFO full: one frame in the reader plus DESC_DEPTH queued
    out_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      build(BCAST, 16'h0800, 64, 40 + k);
      if (k < 17) expect_frame(3'd0);
      send(1);
    end
    chk_ctr(29, 2, 2, 3);
    drain(2000);

    // Reset while a frame is being read out and another is arriving
    out_ready = 1'b1;
    build(BCAST, 16'h0806, 64, 50);
    expect_frame(3'd1);
    send(7);
    build(BCAST, 16'h0800, 64, 51);
    for (int i = 0; i < 7; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < 20; i++) drive(frm[i]);
    @(posedge clk); #1;
    rst   = 1'b1;
    rx_dv = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_sop_eop", 32'({out_sop, out_eop}), 0);
    check("mid_rst_len_ch", 32'({out_len, out_ch}), 0);
    chk_ctr(0, 0, 0, 0);
    build(BCAST, 16'h0800, 64, 52);
    expect_frame(3'd0);
    send(7);
    drain(500);
    chk_ctr(1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
